deserializer_pingpong: RTL and testbench
========================================

// Module: deserializer_pingpong
// PURPOSE
//  Successor to the fixed-length deserializer. Collects BIT_WIDTH samples from a
//  val/rdy stream into frames of runtime-selectable length (1..N_SAMPLES) and
//  presents each frame as a parallel array with its length.
//  Two frame banks (ping-pong): one bank fills while the other waits for send_rdy.
//  Input stalls only when both banks are full.
//  Sits between the serial sample stream and frame-wide consumers (FFT/classifier).
// PARAMETERS
//  N_SAMPLES  8   max samples per frame (power of 2, >=2)
//  BIT_WIDTH  32  bits per sample
//  LW = $clog2(N_SAMPLES)+1 (local) width of length fields
// PORTS
//  clk       in   1             clock, rising edge
//  reset     in   1             synchronous, active-high
//  recv_val  in   1             input sample valid
//  recv_rdy  out  1             input ready
//  recv_msg  in   BIT_WIDTH     input sample
//  cfg_len   in   LW            frame length, sampled at first sample of a frame
//  send_val  out  1             frame valid
//  send_rdy  in   1             consumer ready
//  send_msg  out  BIT_WIDTH x N_SAMPLES (unpacked [N_SAMPLES-1:0]); frame, index 0 = first sample
//  send_len  out  LW            valid entries in send_msg (1..N_SAMPLES)
//  flush     in   1             only with DESER_FLUSH_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, high): banks, lengths and pointers cleared; send_val=0, recv_rdy=1.
//    send_msg all 0, send_len=0. Overrides any in-flight frame or handshake.
//  - State: per-bank full flag, write bank wb, read bank rb, write index wcnt, latched length flen.
//  - recv_rdy = !full[wb] (combinational from registers; never depends on recv_val).
//  - Accept (recv_val & recv_rdy): bank[wb][wcnt] <= recv_msg.
//    If wcnt==0, flen <= eff_len. eff_len = N_SAMPLES when cfg_len==0 or cfg_len>N_SAMPLES, else cfg_len.
//    Last-sample test uses eff_len when wcnt==0, else flen.
//    On last sample: full[wb]<=1, len[wb]<=length, wb toggles, wcnt<=0. Otherwise wcnt++.
//  - cfg_len changes mid-frame are ignored until the next frame starts.
//  - send_val = full[rb]; send_msg = bank[rb]; send_len = len[rb] (muxed from registers).
//  - Release (send_val & send_rdy): full[rb]<=0, rb toggles.
//  - Latency: send_val rises the cycle after the last sample is accepted.
//    Sustained 1 sample/cycle when send_rdy is held high; no bubbles between frames.
//  - Frame completion into one bank and release of the other bank in the same cycle
//    both take effect. The same bank cannot be written and released in one cycle.
//  - Both full: recv_rdy=0. After a release, recv_rdy=1 on the next cycle.
//  - send_msg/send_len stay stable while send_val=1 & send_rdy=0.
//  - Entries at index >= send_len keep stale contents; consumer/bench must not check them.
//  - Frames are emitted strictly in arrival order.
// CONFIGURATION
//  DESER_FLUSH_EN defined: adds port flush.
//   - flush=1 with wcnt>0 closes the current frame early, len = wcnt, plus 1 if a
//     sample is accepted the same cycle (that sample is included).
//   - flush with wcnt==0 and an accept closes a 1-sample frame.
//   - flush with wcnt==0 and no accept is ignored.
//   - flush on a cycle that already completes a frame normally has no extra effect.
//  DESER_FLUSH_EN undefined: no flush port. Frames close only at flen.
// TESTING (N_SAMPLES=8, BIT_WIDTH=32)
//  1 reset mid-frame after 5 samples -> next cycle send_val=0, recv_rdy=1, send_len=0,
//    send_msg all 0; the following 8 samples form a clean frame.
//  2 cfg_len=8, send_rdy=1, feed 1..8 back-to-back -> send_val=1 the cycle after
//    sample 8, send_msg[i]=i+1, send_len=8; then 9..16 continuously forms the next frame with no stall.
//  3 send_rdy=0, recv_val=1 with data 1..17 -> recv_rdy=0 after the 16th accept;
//    raise send_rdy -> frames {1..8} then {9..16}; sample 17 accepted the cycle after the first release.
//  4 cfg_len=3, change to 5 after the first sample -> frame len 3 = {a,b,c};
//    next frame len 5. cfg_len=0 and cfg_len=12 -> len 8.
//  5 alternating random recv_val/send_rdy, 1000 samples, random cfg_len -> scoreboard
//    matches every frame in order; no loss or duplication.
//  6 (DESER_FLUSH_EN) cfg_len=8, 3 samples, then flush with a 4th accept -> send_len=4
//    {s0..s3}; flush at wcnt==0 without accept -> no frame.

Source files
------------

// File: rtl/deserializer_pingpong.sv
// Serial val/rdy samples -> variable-length parallel frames using two ping-pong banks.
// Optional macro DESER_FLUSH_EN adds a flush input that closes the current frame early.
module deserializer_pingpong #(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       recv_val,
    output logic                       recv_rdy,
    input  logic [BIT_WIDTH-1:0]       recv_msg,
    input  logic [$clog2(N_SAMPLES):0] cfg_len,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [BIT_WIDTH-1:0]       send_msg [N_SAMPLES-1:0],
    output logic [$clog2(N_SAMPLES):0] send_len
`ifdef DESER_FLUSH_EN
    ,
    input  logic                       flush
`endif
);
    localparam int LW = $clog2(N_SAMPLES) + 1;
    localparam int WW = $clog2(N_SAMPLES);

    logic [BIT_WIDTH-1:0] bank_q [0:1][N_SAMPLES-1:0];
    logic [BIT_WIDTH-1:0] bank_d [0:1][N_SAMPLES-1:0];
    logic [LW-1:0]        len_q [0:1];
    logic [LW-1:0]        len_d [0:1];
    logic [1:0]           full_q, full_d;
    logic                 wb_q, wb_d, rb_q, rb_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [LW-1:0]        flen_q, flen_d;

    logic          do_acc, do_rel, do_last, do_close, flush_close;
    logic [LW-1:0] eff_len, cur_len, cnt_next, close_len;

    always_comb begin
        recv_rdy = !full_q[wb_q];
        do_acc   = recv_val && recv_rdy;
        do_rel   = full_q[rb_q] && send_rdy;
        cnt_next = {1'b0, wcnt_q} + LW'(1);
        eff_len  = (cfg_len == '0 || cfg_len > LW'(N_SAMPLES)) ? LW'(N_SAMPLES) : cfg_len;
        // The length latched at the first sample only exists from the next cycle on.
        cur_len  = (wcnt_q == '0) ? eff_len : flen_q;
        do_last  = do_acc && (cnt_next == cur_len);
`ifdef DESER_FLUSH_EN
        flush_close = flush && (wcnt_q != '0 || do_acc);
`else
        flush_close = 1'b0;
`endif
        do_close  = do_last || flush_close;
        close_len = do_acc ? cnt_next : {1'b0, wcnt_q};
    end

    always_comb begin
        bank_d = bank_q;
        len_d  = len_q;
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        flen_d = flen_q;
        if (do_acc) begin
            bank_d[wb_q][wcnt_q] = recv_msg;
            if (wcnt_q == '0)
                flen_d = eff_len;
        end
        if (do_close) begin
            full_d[wb_q] = 1'b1;
            len_d[wb_q]  = close_len;
            wb_d         = !wb_q;
            wcnt_d       = '0;
        end else if (do_acc) begin
            wcnt_d = cnt_next[WW-1:0];
        end
        // A filling bank is never full, so this never collides with the write above.
        if (do_rel) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q <= '{default: '0};
            len_q  <= '{default: '0};
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wcnt_q <= '0;
            flen_q <= '0;
        end else begin
            bank_q <= bank_d;
            len_q  <= len_d;
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wcnt_q <= wcnt_d;
            flen_q <= flen_d;
        end
    end

    always_comb begin
        send_val = full_q[rb_q];
        send_len = len_q[rb_q];
        for (int i = 0; i < N_SAMPLES; i++)
            send_msg[i] = bank_q[rb_q][i];
    end

endmodule

// File: tb/tb_deserializer_pingpong.sv
// Directed + table-driven + randomized scoreboard bench for deserializer_pingpong (N=8, W=32).
module tb_deserializer_pingpong;
    localparam int N  = 8;
    localparam int W  = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset, recv_val, recv_rdy, send_val, send_rdy;
    logic [W-1:0]  recv_msg;
    logic [LW-1:0] cfg_len, send_len;
    logic [W-1:0]  send_msg [N-1:0];
`ifdef DESER_FLUSH_EN
    logic          flush;
`endif

    deserializer_pingpong #(.N_SAMPLES(N), .BIT_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg), .cfg_len(cfg_len),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg), .send_len(send_len)
`ifdef DESER_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = !clk;

    typedef struct {
        logic          rv;
        logic [W-1:0]  msg;
        logic [LW-1:0] cfg;
        logic          sr;
        logic          e_rrdy;
        logic          e_sval;
        int            e_len;
        logic [W-1:0]  e_m0;
        logic [W-1:0]  e_ml;
    } vec_t;

    typedef struct {
        int           len;
        logic [W-1:0] d [N];
    } frame_t;

    vec_t   tbl[$];
    frame_t sb[$];
    frame_t cur;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rv, input logic [W-1:0] msg, input logic [LW-1:0] cfg,
                                input logic sval, input int len, input logic [W-1:0] m0,
                                input logic [W-1:0] ml);
        vec_t v;
        v.rv = rv; v.msg = msg; v.cfg = cfg; v.sr = 1'b1; v.e_rrdy = 1'b1;
        v.e_sval = sval; v.e_len = len; v.e_m0 = m0; v.e_ml = ml;
        tbl.push_back(v);
    endfunction

    function automatic int eff(input logic [LW-1:0] c);
        return (c == 0 || c > LW'(N)) ? N : int'(c);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; recv_val = 1'b0; recv_msg = '0; cfg_len = 4'd8; send_rdy = 1'b0;
`ifdef DESER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int m_wcnt, m_flen, acc_total, cyc;
        logic rv, sr, exp_rrdy;
        logic [W-1:0] msg;
        logic [LW-1:0] cfg;

        // Table: back-to-back full frames, then cfg_len latching / clamping.
        for (int i = 0; i < 16; i++)
            add(1'b1, W'(i + 1), 4'd8, i == 8, 8, 32'd1, 32'd8);
        add(1'b0, '0, 4'd8, 1'b1, 8, 32'd9, 32'd16);
        add(1'b0, '0, 4'd8, 1'b0, 0, '0, '0);
        add(1'b1, 32'hA0, 4'd3, 1'b0, 0, '0, '0);
        add(1'b1, 32'hA1, 4'd5, 1'b0, 0, '0, '0);
        add(1'b1, 32'hA2, 4'd5, 1'b0, 0, '0, '0);
        add(1'b1, 32'hB0, 4'd5, 1'b1, 3, 32'hA0, 32'hA2);
        for (int i = 1; i < 5; i++)
            add(1'b1, 32'hB0 + W'(i), 4'd3, 1'b0, 0, '0, '0);
        add(1'b1, 32'hC0, 4'd0, 1'b1, 5, 32'hB0, 32'hB4);
        for (int i = 1; i < 8; i++)
            add(1'b1, 32'hC0 + W'(i), 4'd2, 1'b0, 0, '0, '0);
        add(1'b1, 32'hD0, 4'd12, 1'b1, 8, 32'hC0, 32'hC7);
        for (int i = 1; i < 8; i++)
            add(1'b1, 32'hD0 + W'(i), 4'd1, 1'b0, 0, '0, '0);
        add(1'b0, '0, 4'd8, 1'b1, 8, 32'hD0, 32'hD7);
        add(1'b0, '0, 4'd8, 1'b0, 0, '0, '0);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_sval", 32'(send_val), 32'd0);
        chk("rst_rrdy", 32'(recv_rdy), 32'd1);
        chk("rst_len", 32'(send_len), 32'd0);

        foreach (tbl[r]) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_rrdy", r), 32'(recv_rdy), 32'(tbl[r].e_rrdy));
            chk($sformatf("tbl%0d_sval", r), 32'(send_val), 32'(tbl[r].e_sval));
            if (tbl[r].e_sval) begin
                chk($sformatf("tbl%0d_len", r), 32'(send_len), 32'(tbl[r].e_len));
                chk($sformatf("tbl%0d_m0", r), send_msg[0], tbl[r].e_m0);
                chk($sformatf("tbl%0d_mlast", r), send_msg[tbl[r].e_len - 1], tbl[r].e_ml);
            end
            recv_val = tbl[r].rv; recv_msg = tbl[r].msg; cfg_len = tbl[r].cfg; send_rdy = tbl[r].sr;
        end

        // Reset in the middle of a frame
        do_reset();
        @(negedge clk);
        cfg_len = 4'd8; send_rdy = 1'b0; recv_val = 1'b1;
        for (int k = 0; k < 5; k++) begin
            recv_msg = W'(k + 1);
            @(negedge clk);
        end
        recv_msg = 32'd6; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; recv_val = 1'b0;
        chk("mrst_sval", 32'(send_val), 32'd0);
        chk("mrst_rrdy", 32'(recv_rdy), 32'd1);
        chk("mrst_len", 32'(send_len), 32'd0);
        for (int k = 0; k < N; k++)
            chk($sformatf("mrst_msg%0d", k), send_msg[k], 32'd0);
        recv_val = 1'b1;
        for (int k = 0; k < 8; k++) begin
            recv_msg = 32'h100 + W'(k);
            @(negedge clk);
        end
        recv_val = 1'b0;
        chk("mrst_frame_sval", 32'(send_val), 32'd1);
        chk("mrst_frame_len", 32'(send_len), 32'd8);
        for (int k = 0; k < N; k++)
            chk($sformatf("mrst_frame_msg%0d", k), send_msg[k], 32'h100 + W'(k));

        // Backpressure: both banks fill, then drain
        do_reset();
        @(negedge clk);
        cfg_len = 4'd8; send_rdy = 1'b0; recv_val = 1'b1;
        for (int k = 0; k < 16; k++) begin
            recv_msg = W'(k + 1);
            @(negedge clk);
        end
        recv_msg = 32'd17;
        chk("bp_rrdy_low", 32'(recv_rdy), 32'd0);
        chk("bp_sval", 32'(send_val), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_rrdy_hold", 32'(recv_rdy), 32'd0);
        chk("bp_len_hold", 32'(send_len), 32'd8);
        chk("bp_m0_hold", send_msg[0], 32'd1);
        chk("bp_m7_hold", send_msg[7], 32'd8);
        send_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rrdy_after_rel", 32'(recv_rdy), 32'd1);
        chk("bp_f2_sval", 32'(send_val), 32'd1);
        chk("bp_f2_m0", send_msg[0], 32'd9);
        chk("bp_f2_m7", send_msg[7], 32'd16);
        @(negedge clk);
        chk("bp_empty_sval", 32'(send_val), 32'd0);
        for (int k = 0; k < 7; k++) begin
            recv_msg = W'(18 + k);
            @(negedge clk);
        end
        recv_val = 1'b0;
        chk("bp_f3_sval", 32'(send_val), 32'd1);
        chk("bp_f3_m0", send_msg[0], 32'd17);
        chk("bp_f3_m7", send_msg[7], 32'd24);

`ifdef DESER_FLUSH_EN
        // Early close with a same-cycle accept, then an ignored flush on an empty frame
        do_reset();
        @(negedge clk);
        cfg_len = 4'd8; send_rdy = 1'b0; recv_val = 1'b1;
        for (int k = 0; k < 3; k++) begin
            recv_msg = 32'h60 + W'(k);
            @(negedge clk);
        end
        recv_msg = 32'h63; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; recv_val = 1'b0;
        chk("fl_sval", 32'(send_val), 32'd1);
        chk("fl_len", 32'(send_len), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fl_msg%0d", k), send_msg[k], 32'h60 + W'(k));
        send_rdy = 1'b1;
        @(negedge clk);
        send_rdy = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("fl_idle_sval", 32'(send_val), 32'd0);
        chk("fl_idle_rrdy", 32'(recv_rdy), 32'd1);
`endif

        // Random traffic against a frame scoreboard
        do_reset();
        m_wcnt = 0; m_flen = 0; acc_total = 0; cyc = 0;
        while ((acc_total < 1000 || m_wcnt != 0 || sb.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            exp_rrdy = sb.size() < 2;
            chk("rnd_rrdy", 32'(recv_rdy), 32'(exp_rrdy));
            chk("rnd_sval", 32'(send_val), 32'(sb.size() > 0));
            sr  = (acc_total >= 1000 && m_wcnt == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rv  = (acc_total < 1000 || m_wcnt != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg = LW'($urandom_range(0, 15));
            msg = $urandom;
            if (sr && sb.size() > 0) begin
                chk("rnd_len", 32'(send_len), 32'(sb[0].len));
                for (int k = 0; k < sb[0].len; k++)
                    chk($sformatf("rnd_msg%0d", k), send_msg[k], sb[0].d[k]);
                void'(sb.pop_front());
            end
            if (rv && exp_rrdy) begin
                if (m_wcnt == 0) m_flen = eff(cfg);
                cur.d[m_wcnt] = msg;
                m_wcnt++;
                acc_total++;
                if (m_wcnt == m_flen) begin
                    cur.len = m_flen;
                    sb.push_back(cur);
                    m_wcnt = 0;
                end
            end
            recv_val = rv; recv_msg = msg; cfg_len = cfg; send_rdy = sr;
        end
        chk("rnd_finished_in_budget", 32'(cyc < 20000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
